// File: rtl/axil_arb_pkg.sv
// Shared types and constants for the AXI4-Lite master arbiter.
package axil_arb_pkg;

  typedef enum logic [2:0] {IDLE, WR, WB, RD, RR, RSP} state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axil_master_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request after last_grant,
// wrapping modulo NUM_REQ. The last_grant register lives in the parent.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx
);

  logic found;

  // Walk offsets 1..NUM_REQ from last_grant; the inner loop keeps every index constant.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!found && req[j] && (j == (int'(last_grant) + i) % NUM_REQ)) begin
          grant[j] = 1'b1;
          idx      = IDX_W'(j);
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/axil_master_arbiter.sv
// Shares one AXI4-Lite master port between NUM_REQ requesters, round robin,
// one transaction outstanding. Define AXIL_ARB_TIMEOUT_EN to add a
// TIMEOUT_CYC watchdog that answers SLVERR and drains late responses in IDLE.
module axil_master_arbiter
  import axil_arb_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int ADDR_W      = 6,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                      axi_clk,
  input  logic                      axi_rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic [1:0]                rsp_resp,
  output logic [ADDR_W-1:0]         m_axi_awaddr,
  output logic [2:0]                m_axi_awprot,
  output logic                      m_axi_awvalid,
  input  logic                      m_axi_awready,
  output logic [DATA_W-1:0]         m_axi_wdata,
  output logic [DATA_W/8-1:0]       m_axi_wstrb,
  output logic                      m_axi_wvalid,
  input  logic                      m_axi_wready,
  input  logic [1:0]                m_axi_bresp,
  input  logic                      m_axi_bvalid,
  output logic                      m_axi_bready,
  output logic [ADDR_W-1:0]         m_axi_araddr,
  output logic [2:0]                m_axi_arprot,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  input  logic [DATA_W-1:0]         m_axi_rdata,
  input  logic [1:0]                m_axi_rresp,
  input  logic                      m_axi_rvalid,
  output logic                      m_axi_rready
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t             state;
  logic [IDX_W-1:0]   last_grant, gnt_idx, pick_idx;
  logic [NUM_REQ-1:0] gnt_oh, pick_oh;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic               aw_done, w_done;
  logic               aw_hs, w_hs;

  assign aw_hs = m_axi_awvalid & m_axi_awready;
  assign w_hs  = m_axi_wvalid & m_axi_wready;

  // One address register serves both channels; only one is ever in use.
  assign m_axi_awaddr = addr_q;
  assign m_axi_araddr = addr_q;
  assign m_axi_wdata  = wdata_q;
  assign m_axi_awprot = 3'b000;
  assign m_axi_arprot = 3'b000;
  assign m_axi_wstrb  = '1;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
    .req       (req_valid),
    .last_grant(last_grant),
    .grant     (pick_oh),
    .idx       (pick_idx)
  );

`ifdef AXIL_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt;
  logic             busy, done_now, tmo_hit;
  assign busy     = (state != IDLE) && (state != RSP);
  assign done_now = ((state == WB) && m_axi_bvalid) || ((state == RR) && m_axi_rvalid);
  // Firing two short of the limit lands rsp_valid exactly TIMEOUT_CYC cycles
  // after leaving IDLE, once the RSP cycle and the registered pulse are counted.
  assign tmo_hit  = busy && !done_now && (cnt == CNT_W'(TIMEOUT_CYC - 2));
`endif

  // Transaction FSM; every handshake and response output is registered here.
  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) begin
      state         <= IDLE;
      last_grant    <= IDX_W'(NUM_REQ - 1);
      gnt_idx       <= '0;
      gnt_oh        <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      req_ready     <= '0;
      rsp_valid     <= '0;
      rsp_rdata     <= '0;
      rsp_resp      <= RESP_OKAY;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
`ifdef AXIL_ARB_TIMEOUT_EN
      cnt           <= '0;
`endif
    end else begin
      req_ready <= '0;
      rsp_valid <= '0;
`ifdef AXIL_ARB_TIMEOUT_EN
      if (busy) cnt <= cnt + 1'b1;
`endif
      case (state)
        IDLE: begin
`ifdef AXIL_ARB_TIMEOUT_EN
          m_axi_bready <= 1'b1;
          m_axi_rready <= 1'b1;
`endif
          if (|req_valid) begin
            req_ready <= pick_oh;
            gnt_oh    <= pick_oh;
            gnt_idx   <= pick_idx;
            addr_q    <= req_addr[pick_idx*ADDR_W +: ADDR_W];
            wdata_q   <= req_wdata[pick_idx*DATA_W +: DATA_W];
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
`ifdef AXIL_ARB_TIMEOUT_EN
            cnt          <= '0;
            m_axi_bready <= 1'b0;
            m_axi_rready <= 1'b0;
`endif
            if (req_write[pick_idx]) begin
              m_axi_awvalid <= 1'b1;
              m_axi_wvalid  <= 1'b1;
              state         <= WR;
            end else begin
              m_axi_arvalid <= 1'b1;
              state         <= RD;
            end
          end
        end
        WR: begin
          if (aw_hs) begin
            m_axi_awvalid <= 1'b0;
            aw_done       <= 1'b1;
          end
          if (w_hs) begin
            m_axi_wvalid <= 1'b0;
            w_done       <= 1'b1;
          end
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            m_axi_bready <= 1'b1;
            state        <= WB;
          end
        end
        WB: begin
          if (m_axi_bvalid) begin
            m_axi_bready <= 1'b0;
            rsp_resp     <= m_axi_bresp;
            rsp_rdata    <= '0;
            state        <= RSP;
          end
        end
        RD: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            state         <= RR;
          end
        end
        RR: begin
          if (m_axi_rvalid) begin
            m_axi_rready <= 1'b0;
            rsp_rdata    <= m_axi_rdata;
            rsp_resp     <= m_axi_rresp;
            state        <= RSP;
          end
        end
        RSP: begin
          rsp_valid  <= gnt_oh;
          last_grant <= gnt_idx;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
`ifdef AXIL_ARB_TIMEOUT_EN
      if (tmo_hit) begin
        m_axi_awvalid <= 1'b0;
        m_axi_wvalid  <= 1'b0;
        m_axi_arvalid <= 1'b0;
        m_axi_bready  <= 1'b0;
        m_axi_rready  <= 1'b0;
        rsp_resp      <= RESP_SLVERR;
        rsp_rdata     <= '0;
        state         <= RSP;
      end
`endif
    end
  end

endmodule

// File: tb/tb_axil_master_arbiter.sv
// Directed bench for axil_master_arbiter with a small AXI4-Lite slave model.
// Build with AXIL_ARB_TIMEOUT_EN to also exercise the watchdog (TIMEOUT_CYC = 16).
module tb_axil_master_arbiter;
  localparam int NR = 2;
  localparam int AW = 6;
  localparam int DW = 32;
`ifdef AXIL_ARB_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 256;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NR-1:0]    req_valid = '0, req_write = '0;
  logic [NR*AW-1:0] req_addr = '0;
  logic [NR*DW-1:0] req_wdata = '0;
  logic [NR-1:0]    req_ready, rsp_valid;
  logic [DW-1:0]    rsp_rdata;
  logic [1:0]       rsp_resp;
  logic [AW-1:0]    awaddr, araddr;
  logic [2:0]       awprot, arprot;
  logic             awvalid, wvalid, bready, arvalid, rready;
  logic [DW-1:0]    wdata;
  logic [DW/8-1:0]  wstrb;
  logic             awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
  logic [1:0]       bresp = 2'b00, rresp = 2'b00;
  logic [DW-1:0]    rdata = '0;

  axil_master_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TMO)) dut (
    .axi_clk(clk), .axi_rst(rst),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_araddr(araddr), .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Slave model: register file of 16 words, configurable ready lag and stalls.
  logic [DW-1:0] mem [16];
  int aw_delay = 0, w_delay = 0;
  bit b_block = 1'b0, ar_block = 1'b0;

  initial begin
    bit aw_hs, w_hs, b_hs, ar_hs, r_hs, have_aw, have_w, b_pend;
    int aw_wait, w_wait;
    logic [AW-1:0] aw_a, ar_a;
    logic [DW-1:0] w_d;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    have_aw = 0; have_w = 0; b_pend = 0; aw_wait = 0; w_wait = 0; aw_a = '0; ar_a = '0; w_d = '0;
    forever begin
      @(negedge clk);
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      b_hs  = bvalid && bready;
      ar_hs = arvalid && arready;
      r_hs  = rvalid && rready;
      if (awvalid && !aw_hs) aw_wait++;
      if (wvalid && !w_hs) w_wait++;
      if (aw_hs) aw_a = awaddr;
      if (w_hs) w_d = wdata;
      if (ar_hs) ar_a = araddr;
      @(posedge clk); #1;
      if (rst) begin
        awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
        have_aw = 0; have_w = 0; b_pend = 0; aw_wait = 0; w_wait = 0;
      end else begin
        if (aw_hs) begin have_aw = 1; aw_wait = 0; end
        if (w_hs) begin have_w = 1; w_wait = 0; end
        if (b_hs) bvalid = 0;
        if (r_hs) rvalid = 0;
        if (have_aw && have_w) begin
          mem[aw_a[5:2]] = w_d;
          have_aw = 0; have_w = 0; b_pend = 1;
        end
        if (b_pend && !b_block) begin bvalid = 1; bresp = 2'b00; b_pend = 0; end
        if (ar_hs) begin rdata = mem[ar_a[5:2]]; rresp = 2'b00; rvalid = 1; end
        awready = awvalid && (aw_wait >= aw_delay);
        wready  = wvalid && (w_wait >= w_delay);
        arready = arvalid && !ar_block;
      end
    end
  end

  // Bus monitor sampled mid-cycle.
  int g_n = 0, rsp_n = 0, b_n = 0, ovl = 0, awv_only = 0, early = 0, aw_cyc = 0, w_cyc = 0;
  logic [NR-1:0] g_log [16];
  int g_cyc [16];
  logic [AW-1:0]   aw_addr_q = '0;
  logic [DW/8-1:0] aw_strb_q = '0;
  logic [DW-1:0]   w_data_q = '0, rsp_last = '0;
  initial begin
    bit busy;
    busy = 0;
    forever begin
      @(negedge clk);
      if (rst) busy = 0;
      if (req_ready != 0) begin
        if (busy) ovl++;
        busy = 1;
        if (g_n < 16) begin g_log[g_n] = req_ready; g_cyc[g_n] = cyc; g_n++; end
      end
      if (rsp_valid != 0) begin rsp_n++; busy = 0; rsp_last = rsp_rdata; end
      if (awvalid && awready) begin aw_cyc = cyc; aw_addr_q = awaddr; aw_strb_q = wstrb; end
      if (wvalid && wready) begin w_cyc = cyc; w_data_q = wdata; end
      if (bvalid && bready) b_n++;
      if ((awvalid || wvalid) && arvalid) ovl++;
      if (awvalid && !wvalid) awv_only++;
      if (bready && (awvalid || wvalid)) early++;
    end
  end

  // Drive one request, wait for grant then response; lat counts cycles from grant to rsp.
  task automatic issue(input string tag, input int r, input bit wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, output int lat, output logic [DW-1:0] rd,
                       output logic [1:0] rs);
    int n, t0;
    logic [NR-1:0] one;
    one = 1;
    @(negedge clk);
    req_valid[r] = 1'b1;
    req_write[r] = wr;
    req_addr[r*AW +: AW] = a;
    req_wdata[r*DW +: DW] = d;
    n = 0;
    do begin @(negedge clk); n++; end while (req_ready == 0 && n < 20);
    chk({tag, "/grant"}, req_ready, one << r);
    chk({tag, "/grant_lat"}, n, 1);
    req_valid[r] = 1'b0;
    t0 = cyc;
    n = 0;
    while (rsp_valid == 0 && n < 100) begin @(negedge clk); n++; end
    chk({tag, "/rsp"}, rsp_valid, one << r);
    lat = cyc - t0;
    rd = rsp_rdata;
    rs = rsp_resp;
  endtask

  initial begin
    int lat, n, s0, s1, s2, s3;
    logic [DW-1:0] rd;
    logic [1:0] rs;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ctl", {req_ready, rsp_valid, awvalid, wvalid, bready, arvalid, rready}, 0);
    chk("rst_rsp", {rsp_rdata, rsp_resp}, 0);
    chk("rst_bus", {awaddr, araddr, wdata}, 0);
    chk("const", {awprot, arprot, wstrb}, {3'b000, 3'b000, 4'hF});
    rst = 1'b0;
    @(negedge clk);

    // Single write, then readback of config_reg2 by the other requester
    issue("wr0", 0, 1'b1, 6'h08, 32'hDEADBEEF, lat, rd, rs);
    #1;
    chk("wr0/lat", lat, 3);
    chk("wr0/resp", rs, 2'b00);
    chk("wr0/rdata", rd, 0);
    chk("wr0/aw", {aw_addr_q, aw_strb_q}, {6'h08, 4'hF});
    chk("wr0/wdata", w_data_q, 32'hDEADBEEF);
    chk("wr0/mem", mem[2], 32'hDEADBEEF);
    issue("rdback", 1, 1'b0, 6'h08, 32'h0, lat, rd, rs);
    chk("rdback/lat", lat, 3);
    chk("rdback/data", rd, 32'hDEADBEEF);

    // Round robin, both requesters continuously valid (last grant was 1)
    @(negedge clk); #1;
    g_n = 0; s0 = rsp_n; s1 = ovl;
    req_write = 2'b01;
    req_addr = {6'h08, 6'h0C};
    req_wdata[0 +: DW] = 32'hA5A5A5A5;
    req_valid = 2'b11;
    n = 0;
    while (g_n < 4 && n < 40) begin @(negedge clk); #1; n++; end
    req_valid = 2'b00;
    chk("rr/count", g_n, 4);
    for (int k = 0; k < 4; k++) chk("rr/order", g_log[k], (k % 2 == 0) ? 2'b01 : 2'b10);
    for (int k = 1; k < 4; k++) chk("rr/spacing", g_cyc[k] - g_cyc[k-1], 4);
    n = 0;
    while (rsp_n < s0 + 4 && n < 20) begin @(negedge clk); #1; n++; end
    chk("rr/rsps", rsp_n - s0, 4);
    chk("rr/last_rdata", rsp_last, 32'hDEADBEEF);
    chk("rr/mem", mem[3], 32'hA5A5A5A5);
    chk("rr/overlap", ovl - s1, 0);

    // Split handshakes: W accepted, AW accepted three cycles later
    aw_delay = 3;
    s0 = awv_only; s1 = b_n; s2 = early;
    issue("split", 0, 1'b1, 6'h04, 32'h12345678, lat, rd, rs);
    #1;
    chk("split/aw_only", awv_only - s0, 3);
    chk("split/gap", aw_cyc - w_cyc, 3);
    chk("split/b_once", b_n - s1, 1);
    chk("split/no_early_b", early - s2, 0);
    chk("split/lat", lat, 6);
    aw_delay = 0;

    // Read by requester 1
    issue("rd1", 1, 1'b0, 6'h04, 32'h0, lat, rd, rs);
    chk("rd1/data", rd, 32'h12345678);
    chk("rd1/resp_lat", {rs, 8'(lat)}, {2'b00, 8'd3});

    // Grant requester 0 so a non-reset last_grant would favour requester 1
    issue("wr0b", 0, 1'b1, 6'h0C, 32'hCAFEF00D, lat, rd, rs);
    chk("wr0b/resp", rs, 2'b00);

    // Reset while waiting for B
    b_block = 1'b1;
    #1 s3 = rsp_n;
    @(negedge clk);
    req_valid[1] = 1'b1; req_write[1] = 1'b1; req_addr[AW +: AW] = 6'h10; req_wdata[DW +: DW] = 32'h0BADF00D;
    n = 0;
    do begin @(negedge clk); n++; end while (req_ready == 0 && n < 20);
    req_valid[1] = 1'b0;
    chk("rstwb/grant", req_ready, 2'b10);
    n = 0;
    while (!bready && n < 20) begin @(negedge clk); n++; end
    chk("rstwb/in_wb", bready, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("rstwb/async_ctl", {req_ready, rsp_valid, awvalid, wvalid, bready, arvalid, rready}, 0);
    chk("rstwb/async_bus", {awaddr, wdata, rsp_rdata, rsp_resp}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0; b_block = 1'b0;
    #1;
    chk("rstwb/no_rsp", rsp_n - s3, 0);
    @(negedge clk);
    req_write = 2'b00; req_addr = {6'h08, 6'h04}; req_valid = 2'b11;
    n = 0;
    do begin @(negedge clk); n++; end while (req_ready == 0 && n < 20);
    req_valid = 2'b00;
    chk("rstwb/regrant", req_ready, 2'b01);
    n = 0;
    while (rsp_valid == 0 && n < 20) begin @(negedge clk); n++; end
    chk("rstwb/rsp", {rsp_valid, rsp_rdata}, {2'b01, 32'h12345678});

`ifdef AXIL_ARB_TIMEOUT_EN
    // Watchdog: slave never accepts AR
    ar_block = 1'b1;
    issue("tmo", 0, 1'b0, 6'h00, 32'h0, lat, rd, rs);
    chk("tmo/lat", lat, 16);
    chk("tmo/resp", rs, 2'b10);
    chk("tmo/rdata", rd, 0);
    chk("tmo/arvalid", arvalid, 1'b0);
    ar_block = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
